odo_share_collector: RTL

Result-capture stage directly downstream of `miner_top` in the odocrypt FPGA design. It watches the one-cycle `ticket2moon` hit strobe and samples the `nonce` register one cycle later, when the miner has updated it. It tags each nonce with the job identifier active when hashing started and queues the pair in a small FIFO. The host/UART side drains the FIFO through a valid/ready handshake.

---
 rtl/odo_pkg.sv | 15 +
 rtl/odo_result_fifo.sv | 66 ++++++
 rtl/odo_share_collector.sv | 100 ++++++++++
 3 files changed

// File: rtl/odo_pkg.sv
// Shared definitions for the odocrypt result path: nonce width, default job
// tag width and the packed {nonce, job} record also consumed by the UART framer.
package odo_pkg;

    localparam int NONCE_W   = 32;
    localparam int JOB_W_DEF = 8;

    typedef struct packed {
        logic [NONCE_W-1:0]   nonce;
        logic [JOB_W_DEF-1:0] job;
    } odo_result_t;

    localparam int RESULT_W = $bits(odo_result_t);

endpackage

// File: rtl/odo_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding {nonce, job} records.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module odo_result_fifo
    import odo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = NONCE_W + JOB_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         pop_ok;
    logic         push_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o = wr_q - rd_q;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // A pop frees the head slot in the same cycle, so a push into a full FIFO
    // is still accepted when it coincides with a pop.
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;
    assign push_ok = push_i & (~full_o | pop_ok) & ~flush_i;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + PTR_ONE;
            if (pop_ok)  rd_d = rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/odo_share_collector.sv
// Captures winning nonces from miner_top, tags them with the job active at
// start_hash rise, and queues them for the host through a valid/ready port.
module odo_share_collector
    import odo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int JOB_W = JOB_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_hash,
    input  logic [JOB_W-1:0]         job_id,
    input  logic                     hit,
    input  logic [NONCE_W-1:0]       hit_nonce,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NONCE_W-1:0]       out_nonce,
    output logic [JOB_W-1:0]         out_job,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int RW = NONCE_W + JOB_W;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic             start_q;
    logic             hit_q;
    logic [JOB_W-1:0] job_q, job_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;
    logic [RW-1:0]    head;

    assign job_d = (start_hash & ~start_q) ? job_id : job_q;

    // hit_nonce becomes valid one cycle after the strobe, so the push is
    // driven by the delayed strobe and tagged with job_q in that same cycle.
    assign pop  = ~fifo_empty & out_ready;
    assign drop = hit_q & fifo_full & ~pop & ~flush;

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc8(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q    <= 1'b0;
            hit_q      <= 1'b0;
            job_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            start_q    <= start_hash;
            hit_q      <= hit;
            job_q      <= job_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    odo_result_fifo #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (hit_q),
        .data_i  ({hit_nonce, job_q}),
        .pop_i   (out_ready),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign out_valid = ~fifo_empty;
    assign out_nonce = head[RW-1:JOB_W];
    assign out_job   = head[JOB_W-1:0];
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
